vga_scene_sequencer: RTL and testbench

Frame-rate controller for the VGA pattern datapath. It derives a one-cycle frame tick from `vsync` and sequences everything that changes per frame: a scroll offset for the pattern generator, the active pattern select, and a 4-level fade used when patterns switch. It sits between `hvsync_generator` and the RGB pattern logic. It replaces per-frame counters clocked directly by `vsync`, so all state lives in the `clk` domain.

---
 rtl/vga_scene_sequencer.sv | 154 +++++++++++++++
 tb/tb_vga_scene_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scene_sequencer.sv
// vga_scene_sequencer: per-frame controller for the VGA pattern datapath.
// Turns vsync into a one-cycle frame tick, advances the scroll offset, and
// sequences pattern changes through a 4-level fade-out / switch / fade-in.
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   vsync                   vertical sync from hvsync_generator (clk domain)
//   speed[1:0]              scroll step in pixels per frame
//   pause                   freezes scroll and dwell counting
//   auto_en                 enables auto-advance after DWELL_FRAMES
//   step_btn                rising edge requests a pattern change
//   frame_tick              one-cycle pulse per frame
//   scroll_x[9:0], scroll_y[9:0]  scroll offsets
//   pattern_sel[1:0]        active pattern index
//   fade[1:0]               brightness, 3 = full, 0 = black
//   busy                    high while a transition is in progress
module vga_scene_sequencer #(
  parameter int unsigned DWELL_FRAMES = 120,
  parameter int unsigned FADE_FRAMES  = 4,
  parameter int unsigned NUM_PATTERNS = 4,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       auto_en,
  input  logic       step_btn,
  output logic       frame_tick,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic [1:0] pattern_sel,
  output logic [1:0] fade,
  output logic       busy
);

  localparam int unsigned DW = $clog2(DWELL_FRAMES);
  localparam int unsigned FW = $clog2(FADE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_FRAMES - 1);
  localparam logic [1:0]    SEL_LAST   = 2'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          vsync_q, step_q;
  logic [DW-1:0] dwell, dwell_d;
  logic [FW-1:0] fade_div, fade_div_d;
  logic [1:0]    fade_d, sel_d;
  logic          busy_d;
  logic          step_rise, show_expire, qual_tick;
  logic [10:0]   x_sum;

  assign step_rise   = step_btn & ~step_q;
  assign show_expire = frame_tick & ~pause & auto_en & (dwell == DWELL_LAST);
  assign qual_tick   = frame_tick & (fade_div == FADE_LAST);
  assign x_sum       = {1'b0, scroll_x} + {9'd0, speed};

  // Edge detectors and registered frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= ~VSYNC_ACTIVE;
      step_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      step_q     <= step_btn;
      frame_tick <= (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
    end
  end

  // Scroll runs independently of the transition state; x carry feeds y
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_x <= '0;
      scroll_y <= '0;
    end else if (frame_tick && !pause) begin
      scroll_x <= x_sum[9:0];
      scroll_y <= scroll_y + {9'd0, x_sum[10]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SHOW;
    else       state <= state_d;
  end

  // Next-state logic; a step edge and dwell expiry together give one transition
  always_comb begin
    state_d = state;
    case (state)
      SHOW:     if (step_rise || show_expire)      state_d = FADE_OUT;
      FADE_OUT: if (qual_tick && fade == 2'd0)     state_d = FADE_IN;
      FADE_IN:  if (qual_tick && fade == 2'd2)     state_d = SHOW;
      default:                                     state_d = SHOW;
    endcase
  end

  // Next values for dwell, fade divider, fade level and pattern select
  always_comb begin
    dwell_d    = dwell;
    fade_div_d = fade_div;
    fade_d     = fade;
    sel_d      = pattern_sel;
    busy_d     = (state_d != SHOW);
    case (state)
      SHOW: begin
        if (step_rise || show_expire) begin
          dwell_d    = '0;
          fade_div_d = '0;
        end else if (!auto_en) begin
          dwell_d = '0;
        end else if (frame_tick && !pause) begin
          dwell_d = dwell + DW'(1);
        end
      end
      FADE_OUT: begin
        if (frame_tick) fade_div_d = qual_tick ? '0 : fade_div + FW'(1);
        if (qual_tick) begin
          if (fade != 2'd0) fade_d = fade - 2'd1;
          else              sel_d  = (pattern_sel == SEL_LAST) ? 2'd0 : pattern_sel + 2'd1;
        end
      end
      FADE_IN: begin
        if (frame_tick) fade_div_d = qual_tick ? '0 : fade_div + FW'(1);
        if (qual_tick)  fade_d     = fade + 2'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell       <= '0;
      fade_div    <= '0;
      fade        <= 2'd3;
      pattern_sel <= 2'd0;
      busy        <= 1'b0;
    end else begin
      dwell       <= dwell_d;
      fade_div    <= fade_div_d;
      fade        <= fade_d;
      pattern_sel <= sel_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Testbench for vga_scene_sequencer: two instances (4 patterns / 1-frame fade
// steps, and 1 pattern / 2-frame fade steps) share stimulus and are compared
// each cycle against a tick-counting reference model, plus directed checks.
module tb_vga_scene_sequencer;

  logic       clk = 1'b0;
  logic       reset, vsync, pause, auto_en, step_btn;
  logic [1:0] speed;
  logic       frame_tick0, frame_tick1, busy0, busy1;
  logic [9:0] scroll_x0, scroll_y0, scroll_x1, scroll_y1;
  logic [1:0] pattern_sel0, pattern_sel1, fade0, fade1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  vga_scene_sequencer #(.DWELL_FRAMES(4), .FADE_FRAMES(1), .NUM_PATTERNS(4), .VSYNC_ACTIVE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .vsync(vsync), .speed(speed), .pause(pause),
    .auto_en(auto_en), .step_btn(step_btn), .frame_tick(frame_tick0),
    .scroll_x(scroll_x0), .scroll_y(scroll_y0), .pattern_sel(pattern_sel0),
    .fade(fade0), .busy(busy0));

  vga_scene_sequencer #(.DWELL_FRAMES(3), .FADE_FRAMES(2), .NUM_PATTERNS(1), .VSYNC_ACTIVE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .vsync(vsync), .speed(speed), .pause(pause),
    .auto_en(auto_en), .step_btn(step_btn), .frame_tick(frame_tick1),
    .scroll_x(scroll_x1), .scroll_y(scroll_y1), .pattern_sel(pattern_sel1),
    .fade(fade1), .busy(busy1));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a transition is a count of ticks t in [0, 7*F);
  // k = t/F qualifying ticks give fade 3,2,1,0,0,1,2 and the switch at k=4.
  int p_d[2]  = '{4, 3};
  int p_f[2]  = '{1, 2};
  int p_np[2] = '{4, 1};
  bit m_vq, m_stepq, m_tick, mt_tick, mt_rise, mt_exp;
  int m_sx, m_sy, m_tot;
  bit m_busy[2];
  int m_t[2], m_dwell[2], m_sel[2];

  function automatic int exp_fade(input int i);
    int k;
    if (!m_busy[i]) return 3;
    k = m_t[i] / p_f[i];
    return (k <= 3) ? 3 - k : k - 4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_vq = 1'b1; m_stepq = 1'b0; m_tick = 1'b0; m_sx = 0; m_sy = 0;
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_t[i] = 0; m_dwell[i] = 0; m_sel[i] = 0;
      end
    end else begin
      mt_tick = m_tick;
      mt_rise = step_btn && !m_stepq;
      m_tick  = (vsync == 1'b0) && m_vq;
      m_vq    = vsync;
      m_stepq = step_btn;
      if (mt_tick && !pause) begin
        m_tot = m_sx + int'(speed);
        m_sx  = m_tot % 1024;
        m_sy  = (m_sy + m_tot / 1024) % 1024;
      end
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          mt_exp = mt_tick && !pause && auto_en && (m_dwell[i] == p_d[i] - 1);
          if (mt_rise || mt_exp) begin
            m_busy[i] = 1'b1; m_t[i] = 0; m_dwell[i] = 0;
          end else if (!auto_en) m_dwell[i] = 0;
          else if (mt_tick && !pause) m_dwell[i]++;
        end else if (mt_tick) begin
          m_t[i]++;
          if (m_t[i] == 4 * p_f[i]) m_sel[i] = (m_sel[i] + 1) % p_np[i];
          if (m_t[i] == 7 * p_f[i]) m_busy[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (frame_tick0 === 1'b1) tick_cnt++;
    if (chk_en) begin
      check_val("tick0",   32'(frame_tick0),  32'(m_tick));
      check_val("tick1",   32'(frame_tick1),  32'(m_tick));
      check_val("sx0",     32'(scroll_x0),    32'(m_sx));
      check_val("sy0",     32'(scroll_y0),    32'(m_sy));
      check_val("sx1",     32'(scroll_x1),    32'(m_sx));
      check_val("sy1",     32'(scroll_y1),    32'(m_sy));
      check_val("busy0",   32'(busy0),        32'(m_busy[0]));
      check_val("busy1",   32'(busy1),        32'(m_busy[1]));
      check_val("fade0",   32'(fade0),        32'(exp_fade(0)));
      check_val("fade1",   32'(fade1),        32'(exp_fade(1)));
      check_val("sel0",    32'(pattern_sel0), 32'(m_sel[0]));
      check_val("sel1",    32'(pattern_sel1), 32'(m_sel[1]));
    end
  end

  // One frame: vsync low for 'low' cycles; optional step pulse at cycle step_at.
  // step_at == 1 lines the step rise up with the frame-tick edge.
  task automatic frame(input int period, input int low, input int step_at);
    for (int c = 0; c < period; c++) begin
      vsync    = (c < low) ? 1'b0 : 1'b1;
      step_btn = (c == step_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic frames(input int n);
    for (int j = 0; j < n; j++) frame(12, 2, -1);
  endtask

  int t0, sel_before, per, steppos;
  bit found;

  initial begin
    reset = 1'b1; vsync = 1'b1; speed = 2'd0; pause = 1'b0;
    auto_en = 1'b0; step_btn = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_tick",  32'(frame_tick0),  0);
    check_val("rst_sx",    32'(scroll_x0),    0);
    check_val("rst_sy",    32'(scroll_y0),    0);
    check_val("rst_sel",   32'(pattern_sel0), 0);
    check_val("rst_fade",  32'(fade0),        3);
    check_val("rst_busy",  32'(busy0),        0);

    // One tick per vsync pulse, including a long low hold
    t0 = tick_cnt;
    for (int j = 0; j < 5; j++) frame(100, 2, -1);
    check_val("tick_per_pulse", 32'(tick_cnt - t0), 5);
    t0 = tick_cnt;
    frame(40, 30, -1);
    check_val("tick_held_low", 32'(tick_cnt - t0), 1);

    // Scroll: 342 * 3 = 1026 -> x=2, y=1; then paused
    speed = 2'd3;
    frames(342);
    check_val("scroll_x_342", 32'(scroll_x0), 2);
    check_val("scroll_y_342", 32'(scroll_y0), 1);
    pause = 1'b1;
    frames(10);
    check_val("pause_x", 32'(scroll_x0), 2);
    check_val("pause_y", 32'(scroll_y0), 1);
    pause = 1'b0; speed = 2'd0;

    // Auto-advance with dwell 4, one frame per fade step
    auto_en = 1'b1;
    frames(3);
    check_val("auto_busy_t3", 32'(busy0), 0);
    frames(1);
    check_val("auto_busy_t4", 32'(busy0), 1);
    check_val("auto_fade_t4", 32'(fade0), 3);
    frames(3);
    check_val("auto_fade_t7", 32'(fade0), 0);
    check_val("auto_sel_t7",  32'(pattern_sel0), 0);
    frames(1);
    check_val("auto_sel_t8",  32'(pattern_sel0), 1);
    frames(3);
    check_val("auto_busy_t11", 32'(busy0), 0);
    check_val("auto_fade_t11", 32'(fade0), 3);
    auto_en = 1'b0;
    frames(16);

    // Step button to pattern 3, then wrap with a dropped second press
    for (int j = 0; j < 2; j++) begin
      frame(12, 2, 5);
      frames(16);
    end
    check_val("step_sel3", 32'(pattern_sel0), 3);
    frame(12, 2, 5);
    frames(3);
    frame(12, 2, 5);
    frames(16);
    check_val("wrap_sel", 32'(pattern_sel0), 0);
    check_val("wrap_busy", 32'(busy0), 0);

    // Step rise on the same edge as dwell expiry: one transition
    sel_before = int'(pattern_sel0);
    auto_en = 1'b1;
    frames(3);
    frame(12, 2, 1);
    check_val("simul_busy", 32'(busy0), 1);
    frames(7);
    check_val("simul_sel", 32'(pattern_sel0), 32'((sel_before + 1) % 4));
    check_val("simul_done", 32'(busy0), 0);
    check_val("np1_sel", 32'(pattern_sel1), 0);
    auto_en = 1'b0;
    frames(16);

    // Randomized frames with occasional resets
    for (int j = 0; j < 250; j++) begin
      speed   = 2'($urandom_range(0, 3));
      pause   = ($urandom_range(0, 3) == 0);
      auto_en = ($urandom_range(0, 4) != 0);
      per     = int'($urandom_range(6, 20));
      steppos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
      end
      frame(per, int'($urandom_range(1, 3)), steppos);
    end

    // Reset in the middle of a fade-out
    auto_en = 1'b0; pause = 1'b0; speed = 2'd2;
    frames(20);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      vsync    = ((c % 12) < 2) ? 1'b0 : 1'b1;
      step_btn = (c == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (busy0 === 1'b1 && fade0 === 2'd1) found = 1'b1;
    end
    check_val("midfade_reached", 32'(found), 1);
    reset = 1'b1; vsync = 1'b1; step_btn = 1'b0;
    @(negedge clk);
    check_val("midrst_fade", 32'(fade0),        3);
    check_val("midrst_busy", 32'(busy0),        0);
    check_val("midrst_sel",  32'(pattern_sel0), 0);
    check_val("midrst_sx",   32'(scroll_x0),    0);
    check_val("midrst_sy",   32'(scroll_y0),    0);
    reset = 1'b0;
    frames(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
